// File: rtl/req_arbiter8.sv
// 8-requester arbiter: highest-index-first or round-robin selection,
// grant held until owner drops its request or the hold limit expires.
module req_arbiter8 #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       rr_mode,
  output logic [7:0] gnt,
  output logic [2:0] gnt_id,
  output logic       gnt_valid,
  output logic       timeout
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);
  localparam bit               HOLD_EN  = (MAX_HOLD != 0);

  state_t           state;
  state_t           state_nxt;
  logic [2:0]       last_id;
  logic [CNT_W-1:0] hold_cnt;

  logic [2:0]       fix_id;
  logic [2:0]       rr_id;
  logic [2:0]       win_id;
  logic             own_req;
  logic             hold_hit;

  logic [7:0]       gnt_d;
  logic [2:0]       id_d;
  logic             vld_d;
  logic             to_d;
  logic [2:0]       last_d;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    fix_id = '0;
    for (int i = 0; i < 8; i++)
      if (req[i]) fix_id = 3'(i);
  end

  // Walk from lowest to highest priority so the last hit wins;
  // k=8 wraps to last_id itself, the previous owner.
  always_comb begin
    rr_id = '0;
    for (int k = 8; k >= 1; k--)
      if (req[last_id - 3'(k)]) rr_id = last_id - 3'(k);
  end

  assign win_id   = rr_mode ? rr_id : fix_id;
  assign own_req  = req[gnt_id];
  assign hold_hit = HOLD_EN && (hold_cnt == HOLD_LIM);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_id    <= '0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
      last_id   <= '0;
      hold_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      gnt       <= gnt_d;
      gnt_id    <= id_d;
      gnt_valid <= vld_d;
      timeout   <= to_d;
      last_id   <= last_d;
      hold_cnt  <= cnt_d;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (|req) state_nxt = BUSY;
      BUSY: if (!own_req || hold_hit) state_nxt = IDLE;
    endcase
  end

  always_comb begin
    gnt_d  = gnt;
    id_d   = gnt_id;
    vld_d  = gnt_valid;
    to_d   = 1'b0;
    last_d = last_id;
    cnt_d  = hold_cnt;
    unique case (state)
      IDLE: begin
        if (|req) begin
          gnt_d  = 8'b1 << win_id;
          id_d   = win_id;
          vld_d  = 1'b1;
          last_d = win_id;
          cnt_d  = CNT_W'(1);
        end
      end
      BUSY: begin
        if (!own_req) begin
          gnt_d = '0;
          vld_d = 1'b0;
        end else if (hold_hit) begin
          gnt_d = '0;
          vld_d = 1'b0;
          to_d  = 1'b1;
        end else begin
          cnt_d = hold_cnt + 1'b1;
        end
      end
    endcase
  end

endmodule

// File: doc/req_arbiter8.md
Name: req_arbiter8

Overview:
- Sequential 8-requester arbiter that grants one shared resource to exactly one requester at a time.
- Selection uses a highest-index-first priority encode, the same bit ordering as the team's 8:3 encoder.
- Optional round-robin mode rotates priority after each grant.
- Each grant is held until the owner drops its request or a hold-timeout fires.
- Sits in front of shared muxed datapaths; gnt_id drives the select of the downstream 8:1 mux.

Parameters:
MAX_HOLD, 16, max consecutive cycles a grant is held; 0 = unlimited (timeout disabled)
CNT_W, 5, width of hold counter; must satisfy 2^CNT_W > MAX_HOLD

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
req  input  8  request vector, bit i = requester i
rr_mode  input  1  0 = fixed priority, 1 = round-robin; sampled only in IDLE
gnt  output  8  one-hot grant, registered
gnt_id  output  3  binary index of current/last grant, registered
gnt_valid  output  1  high while any grant is active (equals |gnt)
timeout  output  1  one-cycle pulse when a grant is force-released by MAX_HOLD

Behaviour:
- Reset, sampled on clk edge while rst=1:
  - state=IDLE, gnt=0, gnt_id=0, gnt_valid=0, timeout=0, last_id=0, hold_cnt=0.
  - Reset mid-grant drops gnt at that same edge.
- States: IDLE, BUSY. All outputs are registered.
- IDLE:
  - If req==0: remain IDLE, outputs unchanged except timeout<=0.
  - If req!=0: the winner W is selected combinationally. At the next edge: gnt<=1<<W, gnt_id<=W, gnt_valid<=1, last_id<=W, hold_cnt<=1, state<=BUSY.
  - Latency: request sampled at edge k gives gnt visible after edge k+1, i.e. 1 cycle.
- Fixed priority (rr_mode=0): highest set index wins (bit 7 over bit 6 ... over bit 0).
- Round-robin (rr_mode=1):
  - Candidate order is last_id-1, last_id-2, ..., last_id, descending mod 8. The first set bit wins.
  - After reset (last_id=0) the order is 7..0, identical to fixed priority.
  - The previous owner always has lowest priority.
- BUSY, evaluated each cycle, in priority order:
  1. req[gnt_id]==0 → next edge: gnt<=0, gnt_valid<=0, state<=IDLE, timeout<=0.
  2. MAX_HOLD!=0 and hold_cnt==MAX_HOLD → next edge: gnt<=0, gnt_valid<=0, timeout<=1, state<=IDLE.
  3. Otherwise: hold_cnt<=hold_cnt+1, grant unchanged.
- gnt is therefore high for at most MAX_HOLD consecutive cycles.
- Release always passes through one IDLE cycle: minimum one gnt=0 cycle between grants, no back-to-back handoff.
- Requests from non-owners during BUSY are ignored; they are not latched, and arbitration uses req as sampled in IDLE.
- A requester that deasserts before being granted is simply not selected.
- gnt_id holds its last value after release and is meaningful only when gnt_valid=1.
- rr_mode changes during BUSY take effect at the next IDLE evaluation.
- Timeout with fixed priority: the same requester may win again immediately after the IDLE cycle. This is intended; starvation protection requires rr_mode=1.
- Invariant: gnt is zero or one-hot; gnt_valid==|gnt; gnt==1<<gnt_id whenever gnt_valid=1.

Test Plan:
- Reset/idle: rst=1 for 2 cycles, then req=0x00 for 5 cycles → gnt=0x00, gnt_valid=0, gnt_id=0, timeout=0 throughout.
- Fixed priority: rr_mode=0, req=0x2C held for 3 cycles, then 0x0C → gnt=0x20, gnt_id=5 one cycle after req. Gnt drops one cycle after bit5 falls. After the IDLE cycle, gnt=0x08, gnt_id=3.
- Round-robin rotation: rr_mode=1, req=0x81 constant, each owner drops its req for 1 cycle after 2 cycles of grant → grants alternate 0x80, 0x01, 0x80, 0x01…, each separated by exactly one gnt=0 cycle.
- Timeout: MAX_HOLD=4, rr_mode=1, req=0x0A constant → gnt=0x08 for exactly 4 cycles, then gnt=0 with timeout=1 for 1 cycle, then gnt=0x02. Repeat with rr_mode=0 → gnt returns to 0x08.
- Reset mid-grant: gnt=0x10 active, assert rst for 1 cycle → gnt=0 and last_id=0 after that edge. With req=0x11 and rr_mode=1 after reset, the next grant is 0x10.
- MAX_HOLD=0: req=0x04 held 100 cycles → gnt=0x04 continuously, timeout never asserts. One-hot/valid invariants are checked every cycle across random req and rr_mode stimulus.
